// File: rtl/fft_bf_scheduler.sv
// Butterfly issue/write-back sequencer for an in-place radix-2 DIT FFT over N = 2^LOG2N points.
// Optional o_stage_done port is compiled in when FFT_SCHED_STAGE_DONE_EN is defined.
module fft_bf_scheduler #(
  parameter int LOG2N  = 3,
  parameter int BF_LAT = 1
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             i_start,
  input  logic             i_issue_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_issue_valid,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_twiddle,
  output logic [3:0]       o_stage,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
`ifdef FFT_SCHED_STAGE_DONE_EN
  output logic [LOG2N-1:0] o_wr_addr_b,
  output logic             o_stage_done
`else
  output logic [LOG2N-1:0] o_wr_addr_b
`endif
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int W  = LOG2N + 1;
  localparam int OW = $clog2(BF_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k_reg;
  logic [3:0]      stage_reg;
  logic [OW-1:0]   outstanding_reg;
  logic [OW-1:0]   outstanding_next;
  logic            handshake;

  logic [KW-1:0]   calc_k;
  logic [3:0]      calc_s;
  logic [W-1:0]    calc_kw;
  logic [W-1:0]    calc_span;
  logic [W-1:0]    calc_pos;
  logic [W-1:0]    calc_base;
  logic [4:0]      calc_tw_shift;
  logic [AW-1:0]   next_a;
  logic [AW-1:0]   next_b;
  logic [KW-1:0]   next_tw;

  logic [BF_LAT-1:0]         dl_v;
  logic [BF_LAT-1:0][AW-1:0] dl_a;
  logic [BF_LAT-1:0][AW-1:0] dl_b;

  assign handshake = o_issue_valid & i_issue_ready;
  assign o_stage   = stage_reg;

  // Address of the butterfly that will be presented next: k+1 within the stage,
  // or k=0 of the following stage when leaving DRAIN (k=0, stage 0 from IDLE).
  always_comb begin
    calc_k = '0;
    calc_s = '0;
    case (state)
      ISSUE: begin
        calc_k = k_reg + KW'(1);
        calc_s = stage_reg;
      end
      DRAIN: calc_s = stage_reg + 4'd1;
      default: ;
    endcase
    calc_kw       = {2'b00, calc_k};
    calc_span     = W'(1) << calc_s;
    calc_pos      = calc_kw & (calc_span - W'(1));
    calc_base     = (calc_kw >> calc_s) << ({1'b0, calc_s} + 5'd1);
    calc_tw_shift = 5'(LOG2N - 1) - {1'b0, calc_s};
    next_a        = AW'(calc_base | calc_pos);
    next_b        = AW'(calc_base | calc_pos) + AW'(calc_span);
    next_tw       = KW'(calc_pos << calc_tw_shift);
  end

  always_comb begin
    outstanding_next = outstanding_reg;
    if (handshake && !o_wr_en)
      outstanding_next = outstanding_reg + OW'(1);
    else if (!handshake && o_wr_en)
      outstanding_next = outstanding_reg - OW'(1);
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state           <= IDLE;
      k_reg           <= '0;
      stage_reg       <= '0;
      outstanding_reg <= '0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_issue_valid   <= 1'b0;
      o_addr_a        <= '0;
      o_addr_b        <= '0;
      o_twiddle       <= '0;
    end else begin
      o_done          <= 1'b0;
      outstanding_reg <= outstanding_next;
      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= ISSUE;
            k_reg         <= '0;
            stage_reg     <= '0;
            o_busy        <= 1'b1;
            o_issue_valid <= 1'b1;
            o_addr_a      <= next_a;
            o_addr_b      <= next_b;
            o_twiddle     <= next_tw;
          end
        end
        ISSUE: begin
          if (handshake) begin
            if (k_reg == {KW{1'b1}}) begin
              state         <= DRAIN;
              o_issue_valid <= 1'b0;
            end else begin
              k_reg     <= k_reg + KW'(1);
              o_addr_a  <= next_a;
              o_addr_b  <= next_b;
              o_twiddle <= next_tw;
            end
          end
        end
        DRAIN: begin
          // Leave only once the last in-flight result lands, so the next stage reads fresh data.
          if (outstanding_next == '0) begin
            if (stage_reg == 4'(LOG2N - 1)) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state         <= ISSUE;
              stage_reg     <= stage_reg + 4'd1;
              k_reg         <= '0;
              o_issue_valid <= 1'b1;
              o_addr_a      <= next_a;
              o_addr_b      <= next_b;
              o_twiddle     <= next_tw;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Non-stallable datapath model: shifts every cycle regardless of i_issue_ready.
  for (genvar gi = 0; gi < BF_LAT; gi++) begin : gen_dl
    always_ff @(posedge i_CLK or posedge i_RESET) begin
      if (i_RESET) begin
        dl_v[gi] <= 1'b0;
        dl_a[gi] <= '0;
        dl_b[gi] <= '0;
      end else if (gi == 0) begin
        dl_v[gi] <= handshake;
        dl_a[gi] <= o_addr_a;
        dl_b[gi] <= o_addr_b;
      end else begin
        dl_v[gi] <= dl_v[(gi == 0) ? 0 : gi - 1];
        dl_a[gi] <= dl_a[(gi == 0) ? 0 : gi - 1];
        dl_b[gi] <= dl_b[(gi == 0) ? 0 : gi - 1];
      end
    end
  end

  assign o_wr_en     = dl_v[BF_LAT-1];
  assign o_wr_addr_a = dl_a[BF_LAT-1];
  assign o_wr_addr_b = dl_b[BF_LAT-1];

`ifdef FFT_SCHED_STAGE_DONE_EN
  assign o_stage_done = (state == DRAIN) && (outstanding_next == '0);
`endif

endmodule
